// File: rtl/arb_pkg.sv
// Shared types and constants for the 32-source round-robin arbiter.
//   N_SRC       : number of requesters
//   SEL_W       : width of a source index
//   sel_t       : source index type
//   arb_state_t : arbiter FSM state
package arb_pkg;
  localparam int N_SRC = 32;
  localparam int SEL_W = 5;

  typedef logic [SEL_W-1:0] sel_t;
  typedef enum logic {IDLE, HOLD} arb_state_t;
endpackage

// File: rtl/mux32_1_32bit.sv
// 32:1 word multiplexer shared by all requesters.
//   data_i : 32 source words
//   sel    : source index
//   data_o : selected word (combinational)
module mux32_1_32bit #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] data_i [32],
  input  logic [4:0]       sel,
  output logic [WIDTH-1:0] data_o
);
  assign data_o = data_i[sel];
endmodule

// File: rtl/rr_arbiter32.sv
// Round-robin arbiter / sequencer in front of one shared 32:1 mux.
// Picks the first requester at or after the rotating pointer, captures its
// word into a register and offers it downstream with valid/ready.
//   clk, rst_n : clock, async active-low reset
//   req        : per-source request
//   data_i     : per-source word
//   grant      : registered one-hot grant (1<<sel while out_valid)
//   ack        : combinational; source word consumed this cycle
//   sel        : registered select index
//   out_valid  : out_data is valid
//   out_ready  : downstream accepts this cycle
//   out_data   : registered selected word
module rr_arbiter32
  import arb_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_SRC-1:0]  req,
  input  logic [WIDTH-1:0]  data_i [N_SRC],
  output logic [N_SRC-1:0]  grant,
  output logic [N_SRC-1:0]  ack,
  output logic [SEL_W-1:0]  sel,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_data
);

  arb_state_t state;
  sel_t       ptr;

  // Rotate req right by p, take the lowest set bit, add p back.
  // Returns {hit, index}.
  function automatic logic [SEL_W:0] find_winner(input logic [N_SRC-1:0] r,
                                                 input sel_t p);
    logic [2*N_SRC-1:0] dbl;
    logic [N_SRC-1:0]   rot;
    sel_t               off;
    logic               hit;
    dbl = {r, r} >> p;
    rot = dbl[N_SRC-1:0];
    off = '0;
    hit = 1'b0;
    for (int i = N_SRC-1; i >= 0; i--) begin
      if (rot[i]) begin
        off = sel_t'(i);
        hit = 1'b1;
      end
    end
    return {hit, sel_t'(off + p)};
  endfunction

  // While holding, the next search starts just past the current word so the
  // served source drops to lowest priority on a back-to-back transfer.
  sel_t             search_ptr;
  logic [SEL_W:0]   win;
  logic             win_hit;
  sel_t             win_idx;
  logic             load;
  sel_t             mux_sel;
  logic [WIDTH-1:0] mux_word;

  assign search_ptr = (state == HOLD) ? sel_t'(sel + 1'b1) : ptr;
  assign win        = find_winner(req, search_ptr);
  assign win_hit    = win[SEL_W];
  assign win_idx    = win[SEL_W-1:0];
  assign load       = win_hit & ((state == IDLE) | out_ready);

  // The mux follows sel, except on a loading edge where it is steered to the
  // winner so the word is captured in the same cycle as the grant.
  assign mux_sel = load ? win_idx : sel;

  mux32_1_32bit #(.WIDTH(WIDTH)) u_mux (
    .data_i (data_i),
    .sel    (mux_sel),
    .data_o (mux_word)
  );

  assign ack = grant & {N_SRC{out_valid & out_ready}};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= '0;
      sel       <= '0;
      grant     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (win_hit) begin
            sel       <= win_idx;
            grant     <= {{(N_SRC-1){1'b0}}, 1'b1} << win_idx;
            out_data  <= mux_word;
            out_valid <= 1'b1;
            state     <= HOLD;
          end
        end
        HOLD: begin
          if (out_ready) begin
            ptr <= sel_t'(sel + 1'b1);
            if (win_hit) begin
              sel      <= win_idx;
              grant    <= {{(N_SRC-1){1'b0}}, 1'b1} << win_idx;
              out_data <= mux_word;
            end else begin
              grant     <= '0;
              out_valid <= 1'b0;
              state     <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rr_arbiter32.sv
module tb_rr_arbiter32;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] req;
  logic [31:0] data_i [32];
  logic [31:0] grant;
  logic [31:0] ack;
  logic [4:0]  sel;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;

  int tests = 0;
  int fails = 0;

  rr_arbiter32 #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .data_i    (data_i),
    .grant     (grant),
    .ack       (ack),
    .sel       (sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    out_ready = 1'b1;
    req = $urandom;
    for (int i = 0; i < 32; i++) data_i[i] = $urandom;
    repeat (3) tick;
    tests++;
    if (out_valid !== 1'b0 || grant !== 32'h0 || sel !== 5'd0 ||
        out_data !== 32'h0 || ack !== 32'h0) begin
      fails++;
      $display("FAIL reset: valid=%b grant=%h sel=%0d data=%h ack=%h, need all zero",
               out_valid, grant, sel, out_data, ack);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_single;
    req = 32'h0000_0020;
    data_i[5] = 32'h55;
    out_ready = 1'b1;
    tick;
    tests++;
    if (sel !== 5'd5 || grant !== 32'h20 || out_data !== 32'h55 ||
        out_valid !== 1'b1 || ack !== 32'h20) begin
      fails++;
      $display("FAIL single: sel=%0d grant=%h data=%h valid=%b ack=%h, need 5 20 55 1 20",
               sel, grant, out_data, out_valid, ack);
    end
    // 4,5,6 requesting; search must resume at 6
    req = 32'h0000_0070;
    data_i[6] = 32'h66;
    tick;
    tests++;
    if (sel !== 5'd6 || out_data !== 32'h66 || grant !== 32'h40) begin
      fails++;
      $display("FAIL single_next: sel=%0d data=%h grant=%h, need 6 66 40", sel, out_data, grant);
    end
    req = 32'h0;
    tick;
    tests++;
    if (out_valid !== 1'b0 || grant !== 32'h0 || sel !== 5'd6 || out_data !== 32'h66) begin
      fails++;
      $display("FAIL single_idle: valid=%b grant=%h sel=%0d data=%h, need 0 0 6 66",
               out_valid, grant, sel, out_data);
    end
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  task automatic test_full_rotation;
    int exp_i;
    do_reset;
    for (int i = 0; i < 32; i++) data_i[i] = i;
    req = 32'hFFFF_FFFF;
    out_ready = 1'b1;
    for (int k = 0; k < 33; k++) begin
      tick;
      exp_i = k % 32;
      tests++;
      if (sel !== 5'(exp_i) || out_data !== 32'(exp_i) || out_valid !== 1'b1 ||
          grant !== (32'h1 << exp_i)) begin
        fails++;
        $display("FAIL rotation[%0d]: sel=%0d data=%h valid=%b grant=%h, need %0d",
                 k, sel, out_data, out_valid, grant, exp_i);
      end
    end
    req = 32'h0;
    tick;
  endtask

  task automatic test_wrap;
    do_reset;
    data_i[29] = 32'h29;
    data_i[31] = 32'h31;
    data_i[3]  = 32'h03;
    req = 32'h1 << 29;
    out_ready = 1'b1;
    tick;
    tests++;
    if (sel !== 5'd29 || out_data !== 32'h29) begin
      fails++;
      $display("FAIL wrap_29: sel=%0d data=%h, need 29 29", sel, out_data);
    end
    req = 32'h8000_0008;
    tick;
    tests++;
    if (sel !== 5'd31 || out_data !== 32'h31 || grant !== 32'h8000_0000) begin
      fails++;
      $display("FAIL wrap_31: sel=%0d data=%h grant=%h, need 31 31 80000000", sel, out_data, grant);
    end
    tick;
    tests++;
    if (sel !== 5'd3 || out_data !== 32'h03 || grant !== 32'h8) begin
      fails++;
      $display("FAIL wrap_3: sel=%0d data=%h grant=%h, need 3 03 8", sel, out_data, grant);
    end
    req = 32'h0;
    tick;
  endtask

  task automatic test_backpressure;
    data_i[8] = 32'h80;
    data_i[2] = 32'h22;
    req = 32'h100;
    out_ready = 1'b0;
    tick;
    tests++;
    if (sel !== 5'd8 || out_valid !== 1'b1 || out_data !== 32'h80) begin
      fails++;
      $display("FAIL bp_grant: sel=%0d valid=%b data=%h, need 8 1 80", sel, out_valid, out_data);
    end
    for (int c = 0; c < 4; c++) begin
      data_i[8] = 32'h100 + c;
      req = 32'h104;
      tick;
      tests++;
      if (sel !== 5'd8 || out_data !== 32'h80 || grant !== 32'h100 || ack !== 32'h0) begin
        fails++;
        $display("FAIL bp_hold[%0d]: sel=%0d data=%h grant=%h ack=%h, need 8 80 100 0",
                 c, sel, out_data, grant, ack);
      end
    end
    out_ready = 1'b1;
    #1;
    tests++;
    if (ack !== 32'h100) begin
      fails++;
      $display("FAIL bp_ack: ack=%h, need 100", ack);
    end
    req = 32'h4;
    tick;
    tests++;
    if (sel !== 5'd2 || out_data !== 32'h22 || grant !== 32'h4) begin
      fails++;
      $display("FAIL bp_next: sel=%0d data=%h grant=%h, need 2 22 4", sel, out_data, grant);
    end
    req = 32'h0;
    tick;
  endtask

  task automatic test_reset_mid_hold;
    data_i[7] = 32'h77;
    data_i[0] = 32'hA0;
    data_i[5] = 32'h5A;
    req = 32'h80;
    out_ready = 1'b0;
    tick;
    tests++;
    if (out_valid !== 1'b1 || sel !== 5'd7) begin
      fails++;
      $display("FAIL rst_hold_setup: valid=%b sel=%0d, need 1 7", out_valid, sel);
    end
    #2;
    rst_n = 1'b0;
    out_ready = 1'b1;
    #1;
    tests++;
    if (out_valid !== 1'b0 || grant !== 32'h0 || sel !== 5'd0 ||
        out_data !== 32'h0 || ack !== 32'h0) begin
      fails++;
      $display("FAIL rst_async: valid=%b grant=%h sel=%0d data=%h ack=%h, need all zero",
               out_valid, grant, sel, out_data, ack);
    end
    for (int c = 0; c < 3; c++) begin
      tick;
      tests++;
      if (ack !== 32'h0 || out_valid !== 1'b0) begin
        fails++;
        $display("FAIL rst_noack[%0d]: ack=%h valid=%b, need 0 0", c, ack, out_valid);
      end
    end
    // pointer before reset was 3: a stale pointer would pick 5, not 0
    req = 32'h21;
    rst_n = 1'b1;
    tick;
    tests++;
    if (sel !== 5'd0 || out_data !== 32'hA0 || grant !== 32'h1 || out_valid !== 1'b1) begin
      fails++;
      $display("FAIL rst_restart: sel=%0d data=%h grant=%h valid=%b, need 0 A0 1 1",
               sel, out_data, grant, out_valid);
    end
    req = 32'h0;
    tick;
  endtask

  initial begin
    test_reset;
    test_single;
    test_full_rotation;
    test_wrap;
    test_backpressure;
    test_reset_mid_hold;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
